// File: rtl/mem_req_arbiter.sv
// Two-client (icache / dcache) to single main-memory port arbiter.
// Round-robin request grant, write-data burst locking, and in-order
// routing of read-response beats back to the client that issued each read.
module mem_req_arbiter #(
   parameter int unsigned ADDR_BITS       = 28,
   parameter int unsigned DATA_BITS       = 128,
   parameter int unsigned BURST_BEATS     = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   // client 0: instruction cache
   input  logic                   ic_mem_req_val,
   output logic                   ic_mem_req_rdy,
   input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
   input  logic                   ic_mem_req_rw,
   input  logic                   ic_mem_req_data_valid,
   output logic                   ic_mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
   output logic                   ic_mem_resp_val,
   output logic [DATA_BITS-1:0]   ic_mem_resp_data,
   // client 1: data cache
   input  logic                   dc_mem_req_val,
   output logic                   dc_mem_req_rdy,
   input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
   input  logic                   dc_mem_req_rw,
   input  logic                   dc_mem_req_data_valid,
   output logic                   dc_mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
   output logic                   dc_mem_resp_val,
   output logic [DATA_BITS-1:0]   dc_mem_resp_data,
   // main-memory side
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_val,
   input  logic [DATA_BITS-1:0]   mem_resp_data
);

   localparam int unsigned BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_BEATS - 1);
   localparam logic [CNT_W-1:0]  FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {ARB, WDATA} state_t;
   state_t state, state_nxt;

   logic                       prio;       // client that wins the next tie (0 = ic, 1 = dc)
   logic                       wr_owner;
   logic [BEAT_W-1:0]          wr_beat;
   logic [BEAT_W-1:0]          resp_beat;
   logic [MAX_OUTSTANDING-1:0] owner_q;
   logic [PTR_W-1:0]           rd_ptr, wr_ptr;
   logic [CNT_W-1:0]           count;

   logic fifo_full, fifo_empty, head;
   logic ic_elig, dc_elig, any_elig, gnt, gnt_rw;
   logic req_fire, data_fire, resp_fire, resp_last, push, pop;

   assign fifo_full  = (count == FIFO_DEPTH);
   assign fifo_empty = (count == '0);
   assign head       = owner_q[rd_ptr];

   // Eligibility and round-robin grant selection
   always_comb begin
      ic_elig  = ic_mem_req_val & (ic_mem_req_rw | ~fifo_full);
      dc_elig  = dc_mem_req_val & (dc_mem_req_rw | ~fifo_full);
      any_elig = ic_elig | dc_elig;
      if (ic_elig && dc_elig) gnt = prio;
      else                    gnt = dc_elig;
      gnt_rw    = gnt ? dc_mem_req_rw : ic_mem_req_rw;
      req_fire  = (state == ARB) & any_elig & mem_req_rdy;
      data_fire = (state == WDATA) & mem_req_data_ready &
                  (wr_owner ? dc_mem_req_data_valid : ic_mem_req_data_valid);
      resp_fire = mem_resp_val & ~fifo_empty;
      resp_last = resp_fire & (resp_beat == LAST_BEAT);
      push      = req_fire & ~gnt_rw;
      pop       = resp_last;
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ARB;
      else        state <= state_nxt;
   end

   // FSM next-state: a granted write locks the port until its burst completes
   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (req_fire && gnt_rw) state_nxt = WDATA;
         WDATA:   if (data_fire && (wr_beat == LAST_BEAT)) state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   // FSM outputs: request mux in ARB, write-data mux in WDATA, all quiet in reset
   always_comb begin
      mem_req_val           = 1'b0;
      mem_req_addr          = '0;
      mem_req_rw            = 1'b0;
      ic_mem_req_rdy        = 1'b0;
      dc_mem_req_rdy        = 1'b0;
      mem_req_data_valid    = 1'b0;
      mem_req_data_bits     = '0;
      mem_req_data_mask     = '0;
      ic_mem_req_data_ready = 1'b0;
      dc_mem_req_data_ready = 1'b0;
      if (reset) begin
         case (state)
            ARB: begin
               mem_req_val    = any_elig;
               mem_req_addr   = gnt ? dc_mem_req_addr : ic_mem_req_addr;
               mem_req_rw     = gnt_rw;
               ic_mem_req_rdy = any_elig & ~gnt & mem_req_rdy;
               dc_mem_req_rdy = any_elig &  gnt & mem_req_rdy;
            end
            WDATA: begin
               mem_req_data_valid    = wr_owner ? dc_mem_req_data_valid : ic_mem_req_data_valid;
               mem_req_data_bits     = wr_owner ? dc_mem_req_data_bits  : ic_mem_req_data_bits;
               mem_req_data_mask     = wr_owner ? dc_mem_req_data_mask  : ic_mem_req_data_mask;
               ic_mem_req_data_ready = ~wr_owner & mem_req_data_ready;
               dc_mem_req_data_ready =  wr_owner & mem_req_data_ready;
            end
            default: ;
         endcase
      end
   end

   // Priority pointer, write owner and write-beat counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio     <= 1'b1;
         wr_owner <= 1'b0;
         wr_beat  <= '0;
      end else begin
         if (req_fire) begin
            prio <= ~gnt;
            if (gnt_rw) wr_owner <= gnt;
         end
         if (data_fire) wr_beat <= (wr_beat == LAST_BEAT) ? '0 : wr_beat + 1'b1;
      end
   end

   // Read-owner FIFO and response-beat counter; push and pop may coincide
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q   <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         resp_beat <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr] <= gnt;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (resp_fire) resp_beat <= resp_last ? '0 : resp_beat + 1'b1;
      end
   end

   // Response routing to the FIFO-head owner; data broadcast to both clients
   always_comb begin
      ic_mem_resp_val  = reset & resp_fire & ~head;
      dc_mem_resp_val  = reset & resp_fire &  head;
      ic_mem_resp_data = reset ? mem_resp_data : '0;
      dc_mem_resp_data = reset ? mem_resp_data : '0;
   end

   no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
      !(mem_resp_val && fifo_empty));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed table, corner-case
// sequences, and randomized traffic against a queue-based reference model.
module tb_mem_req_arbiter;

   localparam int unsigned AW    = 28;
   localparam int unsigned DW    = 128;
   localparam int unsigned MW    = DW / 8;
   localparam int unsigned BURST = 4;
   localparam int unsigned MAXO  = 4;

   logic          clk, reset;
   logic          ic_val, ic_rdy, ic_rw, ic_dv, ic_dr, ic_rv;
   logic [AW-1:0] ic_addr;
   logic [DW-1:0] ic_bits, ic_rdata;
   logic [MW-1:0] ic_mask;
   logic          dc_val, dc_rdy, dc_rw, dc_dv, dc_dr, dc_rv;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_bits, dc_rdata;
   logic [MW-1:0] dc_mask;
   logic          m_val, m_rdy, m_rw, m_dv, m_dr, m_rv;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_bits, m_rdata;
   logic [MW-1:0] m_mask;

   int n_pass  = 0;
   int n_total = 0;

   mem_req_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .BURST_BEATS(BURST),
                     .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset),
      .ic_mem_req_val(ic_val), .ic_mem_req_rdy(ic_rdy), .ic_mem_req_addr(ic_addr),
      .ic_mem_req_rw(ic_rw), .ic_mem_req_data_valid(ic_dv), .ic_mem_req_data_ready(ic_dr),
      .ic_mem_req_data_bits(ic_bits), .ic_mem_req_data_mask(ic_mask),
      .ic_mem_resp_val(ic_rv), .ic_mem_resp_data(ic_rdata),
      .dc_mem_req_val(dc_val), .dc_mem_req_rdy(dc_rdy), .dc_mem_req_addr(dc_addr),
      .dc_mem_req_rw(dc_rw), .dc_mem_req_data_valid(dc_dv), .dc_mem_req_data_ready(dc_dr),
      .dc_mem_req_data_bits(dc_bits), .dc_mem_req_data_mask(dc_mask),
      .dc_mem_resp_val(dc_rv), .dc_mem_resp_data(dc_rdata),
      .mem_req_val(m_val), .mem_req_rdy(m_rdy), .mem_req_addr(m_addr), .mem_req_rw(m_rw),
      .mem_req_data_valid(m_dv), .mem_req_data_ready(m_dr), .mem_req_data_bits(m_bits),
      .mem_req_data_mask(m_mask), .mem_resp_val(m_rv), .mem_resp_data(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          ic_val, ic_rw;
      logic [AW-1:0] ic_addr;
      logic          dc_val, dc_rw;
      logic [AW-1:0] dc_addr;
      logic          rdy, rval;
      logic [DW-1:0] rdata;
      logic          e_val;
      logic [AW-1:0] e_addr;
      logic          e_rw, e_ic_rdy, e_dc_rdy, e_ic_rv, e_dc_rv;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   int owner_q[$];
   int rbeat, prio, wr_cl, wbeats;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic vec_t row(input logic iv, ir, input logic [AW-1:0] ia,
                                input logic dv, dr, input logic [AW-1:0] da,
                                input logic rdy, rv, input logic [DW-1:0] rd,
                                input logic ev, input logic [AW-1:0] ea,
                                input logic er, eir, edr, eiv, edv);
      vec_t r;
      r.ic_val = iv; r.ic_rw = ir; r.ic_addr = ia;
      r.dc_val = dv; r.dc_rw = dr; r.dc_addr = da;
      r.rdy = rdy; r.rval = rv; r.rdata = rd;
      r.e_val = ev; r.e_addr = ea; r.e_rw = er;
      r.e_ic_rdy = eir; r.e_dc_rdy = edr; r.e_ic_rv = eiv; r.e_dc_rv = edv;
      return r;
   endfunction

   function automatic logic [DW-1:0] pat(input int unsigned k);
      return {4{32'hD000_0000 + k}};
   endfunction

   task automatic idle();
      ic_val = 0; ic_rw = 0; ic_addr = '0; ic_dv = 0; ic_bits = '0; ic_mask = '0;
      dc_val = 0; dc_rw = 0; dc_addr = '0; dc_dv = 0; dc_bits = '0; dc_mask = '0;
      m_rdy = 0; m_dr = 0; m_rv = 0; m_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b1;
      owner_q.delete();
      rbeat = 0; prio = 1; wr_cl = -1; wbeats = 0;
   endtask

   // one randomized cycle: model predicts outputs, then advances on the clock
   task automatic rnd_cycle();
      int  sz, win;
      bit  el0, el1, any, rv_ok, wdv;
      sz  = owner_q.size();
      el0 = ic_val && (ic_rw || sz < int'(MAXO));
      el1 = dc_val && (dc_rw || sz < int'(MAXO));
      any = el0 || el1;
      win = (el0 && el1) ? prio : (el1 ? 1 : 0);
      if (wr_cl < 0) begin
         chk("rnd mem_req_val", m_val, any);
         if (any) begin
            chk("rnd mem_req_addr", m_addr, win ? dc_addr : ic_addr);
            chk("rnd mem_req_rw", m_rw, win ? dc_rw : ic_rw);
         end
         chk("rnd ic_req_rdy", ic_rdy, any && win == 0 && m_rdy);
         chk("rnd dc_req_rdy", dc_rdy, any && win == 1 && m_rdy);
         chk("rnd mem_data_valid", m_dv, 0);
         chk("rnd ic_data_ready", ic_dr, 0);
         chk("rnd dc_data_ready", dc_dr, 0);
      end else begin
         wdv = wr_cl ? dc_dv : ic_dv;
         chk("rnd wd mem_req_val", m_val, 0);
         chk("rnd wd ic_req_rdy", ic_rdy, 0);
         chk("rnd wd dc_req_rdy", dc_rdy, 0);
         chk("rnd wd mem_data_valid", m_dv, wdv);
         chk("rnd wd mem_data_bits", m_bits, wr_cl ? dc_bits : ic_bits);
         chk("rnd wd mem_data_mask", m_mask, wr_cl ? dc_mask : ic_mask);
         chk("rnd wd ic_data_ready", ic_dr, wr_cl == 0 && m_dr);
         chk("rnd wd dc_data_ready", dc_dr, wr_cl == 1 && m_dr);
      end
      rv_ok = m_rv && sz > 0;
      chk("rnd ic_resp_val", ic_rv, rv_ok && owner_q[0] == 0);
      chk("rnd dc_resp_val", dc_rv, rv_ok && owner_q[0] == 1);
      chk("rnd ic_resp_data", ic_rdata, m_rdata);
      chk("rnd dc_resp_data", dc_rdata, m_rdata);
      if (rv_ok) begin
         rbeat++;
         if (rbeat == int'(BURST)) begin
            rbeat = 0;
            void'(owner_q.pop_front());
         end
      end
      if (wr_cl < 0) begin
         if (any && m_rdy) begin
            prio = 1 - win;
            if (win ? dc_rw : ic_rw) begin
               wr_cl = win; wbeats = 0;
            end else owner_q.push_back(win);
         end
      end else if ((wr_cl ? dc_dv : ic_dv) && m_dr) begin
         wbeats++;
         if (wbeats == int'(BURST)) wr_cl = -1;
      end
      tick();
   endtask

   initial begin
      int beat;
      logic dr_seq [5];

      // reset state with stimulus present: every output must stay quiet
      reset = 1'b0;
      idle();
      ic_val = 1; ic_addr = 28'h123; dc_dv = 1; m_rdy = 1; m_dr = 1; m_rdata = 'hBEEF;
      #2;
      chk("rst mem_req_val", m_val, 0);
      chk("rst mem_req_addr", m_addr, 0);
      chk("rst ic_req_rdy", ic_rdy, 0);
      chk("rst dc_data_ready", dc_dr, 0);
      chk("rst mem_data_valid", m_dv, 0);
      chk("rst ic_resp_data", ic_rdata, 0);
      chk("rst ic_resp_val", ic_rv, 0);

      // ---- table: simultaneous reads after reset, then single-client read ----
      vecs.push_back(row(1,0,28'h100, 1,0,28'h200, 1, 0,'0, 1,28'h200,0, 0,1,0,0));
      vecs.push_back(row(1,0,28'h100, 0,0,28'h0,   1, 0,'0, 1,28'h100,0, 1,0,0,0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(row(0,0,0, 0,0,0, 1, 1,DW'(32'hB0 + k), 0,0,0, 0,0,0,1));
      for (int k = 4; k < 8; k++)
         vecs.push_back(row(0,0,0, 0,0,0, 1, 1,DW'(32'hB0 + k), 0,0,0, 0,0,1,0));
      vecs.push_back(row(1,0,28'h10, 0,0,0, 1, 0,'0, 1,28'h10,0, 1,0,0,0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(row(0,0,0, 0,0,0, 1, 1,DW'(32'hA0 + k), 0,0,0, 0,0,1,0));
      vecs.push_back(row(0,0,0, 0,0,0, 1, 0,'0, 0,0,0, 0,0,0,0));

      do_reset();
      foreach (vecs[i]) begin
         ic_val = vecs[i].ic_val; ic_rw = vecs[i].ic_rw; ic_addr = vecs[i].ic_addr;
         dc_val = vecs[i].dc_val; dc_rw = vecs[i].dc_rw; dc_addr = vecs[i].dc_addr;
         m_rdy = vecs[i].rdy; m_rv = vecs[i].rval; m_rdata = vecs[i].rdata;
         #1;
         chk($sformatf("vec%0d mem_req_val", i), m_val, vecs[i].e_val);
         if (vecs[i].e_val) begin
            chk($sformatf("vec%0d mem_req_addr", i), m_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d mem_req_rw", i), m_rw, vecs[i].e_rw);
         end
         chk($sformatf("vec%0d ic_req_rdy", i), ic_rdy, vecs[i].e_ic_rdy);
         chk($sformatf("vec%0d dc_req_rdy", i), dc_rdy, vecs[i].e_dc_rdy);
         chk($sformatf("vec%0d ic_resp_val", i), ic_rv, vecs[i].e_ic_rv);
         chk($sformatf("vec%0d dc_resp_val", i), dc_rv, vecs[i].e_dc_rv);
         chk($sformatf("vec%0d ic_resp_data", i), ic_rdata, vecs[i].rdata);
         chk($sformatf("vec%0d dc_resp_data", i), dc_rdata, vecs[i].rdata);
         tick();
      end

      // ---- dc write burst with ic read waiting, one stalled beat ----
      do_reset();
      dc_val = 1; dc_rw = 1; dc_addr = 28'h20; dc_dv = 1; dc_bits = pat(0); dc_mask = '1;
      m_rdy = 1; m_dr = 1;
      #1;
      chk("wr grant mem_req_val", m_val, 1);
      chk("wr grant addr", m_addr, 28'h20);
      chk("wr grant rw", m_rw, 1);
      chk("wr grant dc_rdy", dc_rdy, 1);
      chk("wr early data_valid", m_dv, 0);
      chk("wr early dc_data_ready", dc_dr, 0);
      tick();
      dc_val = 0;
      ic_val = 1; ic_rw = 0; ic_addr = 28'h30; ic_dv = 1; ic_bits = '1; ic_mask = 16'h00F0;
      dr_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      beat = 0;
      for (int c = 0; c < 5; c++) begin
         dc_bits = pat(beat); m_dr = dr_seq[c];
         #1;
         chk("wd mem_req_val", m_val, 0);
         chk("wd ic_req_rdy", ic_rdy, 0);
         chk("wd mem_data_valid", m_dv, 1);
         chk("wd mem_data_bits", m_bits, pat(beat));
         chk("wd mem_data_mask", m_mask, 16'hFFFF);
         chk("wd dc_data_ready", dc_dr, dr_seq[c]);
         chk("wd ic_data_ready", ic_dr, 0);
         if (dr_seq[c]) beat++;
         tick();
      end
      dc_dv = 0; ic_dv = 0; m_dr = 1;
      #1;
      chk("post-wd ic_req_rdy", ic_rdy, 1);
      chk("post-wd mem_req_addr", m_addr, 28'h30);
      chk("post-wd mem_data_valid", m_dv, 0);
      tick();

      // ---- memory back-pressure: grant must not move while stalled ----
      do_reset();
      ic_val = 1; ic_addr = 28'h40; dc_val = 1; dc_addr = 28'h50; m_rdy = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall mem_req_val", m_val, 1);
         chk("stall mem_req_addr", m_addr, 28'h50);
         chk("stall ic_req_rdy", ic_rdy, 0);
         chk("stall dc_req_rdy", dc_rdy, 0);
         tick();
      end
      m_rdy = 1;
      #1;
      chk("stall release dc_rdy", dc_rdy, 1);
      chk("stall release addr", m_addr, 28'h50);
      tick();
      #1;
      chk("rr next ic_rdy", ic_rdy, 1);
      chk("rr next dc_rdy", dc_rdy, 0);
      chk("rr next addr", m_addr, 28'h40);
      tick();

      // ---- owner FIFO full: reads stall, writes proceed ----
      do_reset();
      ic_val = 1; ic_rw = 0; m_rdy = 1; m_dr = 1;
      for (int c = 0; c < 4; c++) begin
         ic_addr = AW'(32'h60 + c);
         #1;
         chk("fill ic_rdy", ic_rdy, 1);
         chk("fill mem_req_addr", m_addr, AW'(32'h60 + c));
         tick();
      end
      ic_addr = 28'h64;
      #1;
      chk("full ic_rdy", ic_rdy, 0);
      chk("full mem_req_val", m_val, 0);
      dc_val = 1; dc_rw = 1; dc_addr = 28'h70;
      #1;
      chk("full dc write rdy", dc_rdy, 1);
      chk("full dc write rw", m_rw, 1);
      chk("full ic still stalled", ic_rdy, 0);
      tick();
      dc_val = 0; dc_dv = 1;
      for (int c = 0; c < 4; c++) begin
         dc_bits = pat(c);
         #1;
         chk("full wd dc_data_ready", dc_dr, 1);
         chk("full wd ic_rdy", ic_rdy, 0);
         tick();
      end
      dc_dv = 0; m_rv = 1;
      for (int c = 0; c < 4; c++) begin
         m_rdata = DW'(32'hC0 + c);
         #1;
         chk("drain ic_resp_val", ic_rv, 1);
         chk("drain dc_resp_val", dc_rv, 0);
         chk("drain ic_rdy", ic_rdy, 0);
         tick();
      end
      m_rv = 0;
      #1;
      chk("after pop ic_rdy", ic_rdy, 1);
      chk("after pop addr", m_addr, 28'h64);
      tick();

      // ---- reset asserted in the middle of a write burst ----
      do_reset();
      ic_val = 1; ic_addr = 28'h80; m_rdy = 1; m_dr = 1;
      #1;
      chk("pre-rst ic read rdy", ic_rdy, 1);
      tick();
      ic_val = 0; dc_val = 1; dc_rw = 1; dc_addr = 28'h90;
      #1;
      chk("pre-rst dc write rdy", dc_rdy, 1);
      tick();
      dc_val = 0; dc_dv = 1; dc_mask = '1;
      for (int c = 0; c < 2; c++) begin
         dc_bits = pat(c);
         tick();
      end
      dc_bits = pat(2); ic_val = 1; dc_val = 1;
      #1;
      chk("beat2 mem_data_valid", m_dv, 1);
      reset = 1'b0;
      #1;
      chk("midrst mem_req_val", m_val, 0);
      chk("midrst mem_data_valid", m_dv, 0);
      chk("midrst ic_rdy", ic_rdy, 0);
      chk("midrst dc_rdy", dc_rdy, 0);
      chk("midrst dc_data_ready", dc_dr, 0);
      chk("midrst mem_data_bits", m_bits, 0);
      chk("midrst mem_req_addr", m_addr, 0);
      tick();
      idle();
      reset = 1'b1;
      ic_val = 1; m_rdy = 1;
      for (int c = 0; c < 4; c++) begin
         ic_addr = AW'(32'hA0 + c);
         #1;
         chk("postrst read rdy", ic_rdy, 1);
         tick();
      end
      #1;
      chk("postrst fifo full rdy", ic_rdy, 0);
      tick();

      // ---- randomized traffic against the reference model ----
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         ic_val  = 1'($urandom_range(0, 1));
         ic_rw   = ($urandom_range(0, 3) == 0);
         ic_addr = AW'($urandom);
         ic_dv   = 1'($urandom_range(0, 1));
         ic_bits = {$urandom, $urandom, $urandom, $urandom};
         ic_mask = MW'($urandom);
         dc_val  = 1'($urandom_range(0, 1));
         dc_rw   = ($urandom_range(0, 3) == 0);
         dc_addr = AW'($urandom);
         dc_dv   = 1'($urandom_range(0, 1));
         dc_bits = {$urandom, $urandom, $urandom, $urandom};
         dc_mask = MW'($urandom);
         m_rdy   = ($urandom_range(0, 3) != 0);
         m_dr    = 1'($urandom_range(0, 1));
         m_rv    = (owner_q.size() > 0) && ($urandom_range(0, 2) != 0);
         m_rdata = {$urandom, $urandom, $urandom, $urandom};
         #1;
         rnd_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
